// File: rtl/seq_controller.sv
// Clocked control sequencer for the model computer: fetches, decodes and executes
// instructions held in IR, producing datapath strobes; includes multi-cycle MUL/DIV.
module seq_controller #(
  parameter int REG_W         = 2,
  parameter int IR_W          = 8,
  parameter int MULDIV_CYCLES = 3,
  parameter int LO_REG        = 1,
  parameter int HI_REG        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IR_W-1:0]       ir,
  output logic [REG_W-1:0]      src_sel,
  output logic [REG_W-1:0]      dst_sel,
  output logic [(2**REG_W)-1:0] reg_we,
  output logic                  mar_we,
  output logic                  dr_we,
  output logic                  dr_oe,
  output logic                  pc_inc,
  output logic                  ir_we,
  output logic                  alu_en,
  output logic [3:0]            alu_op,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic                  done
);

  localparam int NREG = 2**REG_W;
  localparam int CW   = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CW-1:0]    MD_LAST = CW'((MULDIV_CYCLES > 1) ? MULDIV_CYCLES - 2 : 0);
  localparam logic [REG_W-1:0] LO_SEL  = REG_W'(LO_REG);
  localparam logic [REG_W-1:0] HI_SEL  = REG_W'(HI_REG);

  localparam logic [3:0] OP_HALT = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ILL  = 4'hC;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_O1, S_O2, S_EX,
    S_MD, S_WB, S_WLO, S_WHI, S_HALTED
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           illegal_q, illegal_d;

  logic [3:0]       op;
  logic [REG_W-1:0] dst_f;
  logic [REG_W-1:0] src_f;

  assign op    = ir[IR_W-1 -: 4];
  assign dst_f = ir[2*REG_W-1 -: REG_W];
  assign src_f = ir[REG_W-1:0];

  function automatic state_t ex_next(input logic [3:0] opc);
    if (opc == OP_MUL || opc == OP_DIV)
      return (MULDIV_CYCLES > 1) ? S_MD : S_WLO;
    return S_WB;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // DEC overlaps the first execute (or operand-address) cycle, since ir is valid there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    src_sel   = '0;
    dst_sel   = '0;
    reg_we    = '0;
    mar_we    = 1'b0;
    dr_we     = 1'b0;
    dr_oe     = 1'b0;
    pc_inc    = 1'b0;
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    done      = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_F0;
      S_F0: begin
        mar_we  = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        dr_we   = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        ir_we   = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        dst_sel = dst_f;
        src_sel = src_f;
        cnt_d   = '0;
        if (op == OP_HALT) begin
          state_d = S_HALTED;
        end else if (op >= OP_ILL) begin
          illegal_d = 1'b1;
          state_d   = S_F0;
        end else if (src_f == '0 && op != OP_NOT) begin
          mar_we  = 1'b1;
          state_d = S_O1;
        end else begin
          alu_en  = 1'b1;
          state_d = ex_next(op);
        end
      end
      S_O1: begin
        dst_sel = dst_f;
        src_sel = src_f;
        dr_we   = 1'b1;
        state_d = S_O2;
      end
      S_O2: begin
        dst_sel = dst_f;
        src_sel = src_f;
        dr_oe   = 1'b1;
        reg_we  = NREG'(1);
        pc_inc  = 1'b1;
        state_d = S_EX;
      end
      S_EX: begin
        dst_sel = dst_f;
        src_sel = src_f;
        alu_en  = 1'b1;
        cnt_d   = '0;
        state_d = ex_next(op);
      end
      S_MD: begin
        dst_sel = dst_f;
        src_sel = src_f;
        alu_en  = 1'b1;
        if (cnt_q == MD_LAST) state_d = S_WLO;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      S_WB: begin
        dst_sel = dst_f;
        src_sel = src_f;
        alu_en  = 1'b1;
        reg_we  = NREG'(1) << dst_f;
        done    = 1'b1;
        state_d = S_F0;
      end
      S_WLO: begin
        dst_sel = LO_SEL;
        alu_en  = 1'b1;
        reg_we  = NREG'(1) << LO_SEL;
        state_d = S_WHI;
      end
      S_WHI: begin
        dst_sel = HI_SEL;
        alu_en  = 1'b1;
        reg_we  = NREG'(1) << HI_SEL;
        done    = 1'b1;
        state_d = S_F0;
      end
      S_HALTED: begin
        dst_sel = dst_f;
        src_sel = src_f;
        halted  = 1'b1;
        if (start) state_d = S_F0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign alu_op  = alu_en ? op : 4'h0;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: per-cycle expected output vectors (table plus hand-written
// sequences) queued as stimulus is driven and compared after each rising edge.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ir = 8'h00;
  logic [1:0] src_sel, dst_sel;
  logic [3:0] reg_we;
  logic       mar_we, dr_we, dr_oe, pc_inc, ir_we, alu_en;
  logic [3:0] alu_op;
  logic       busy, halted, illegal, done;

  seq_controller dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir),
    .src_sel(src_sel), .dst_sel(dst_sel), .reg_we(reg_we),
    .mar_we(mar_we), .dr_we(dr_we), .dr_oe(dr_oe), .pc_inc(pc_inc),
    .ir_we(ir_we), .alu_en(alu_en), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         r;
    bit         s;
    logic [7:0] i;
    logic [21:0] x;
  } vec_t;

  vec_t        tbl[$];
  logic [21:0] expq[$];
  string       nameq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Output vector: busy halted illegal done mar dr droe pcinc irwe alu | we | dst | src | op
  function automatic logic [21:0] e(bit b, bit h, bit il, bit d, bit m, bit dw, bit doe,
                                    bit pc, bit iw, bit a, logic [3:0] we,
                                    logic [1:0] ds, logic [1:0] ss, logic [3:0] op);
    return {b, h, il, d, m, dw, doe, pc, iw, a, we, ds, ss, op};
  endfunction

  function automatic void add(string n, bit r, bit s, logic [7:0] i, logic [21:0] x);
    vec_t v;
    v.name = n; v.r = r; v.s = s; v.i = i; v.x = x;
    tbl.push_back(v);
  endfunction

  task automatic check();
    logic [21:0] got, want;
    string       n;
    got  = {busy, halted, illegal, done, mar_we, dr_we, dr_oe, pc_inc, ir_we, alu_en,
            reg_we, dst_sel, src_sel, alu_op};
    want = expq.pop_front();
    n    = nameq.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %06h required %06h at %0t", n, got, want, $time);
    end
  endtask

  task automatic step(string n, bit r, bit s, logic [7:0] i, logic [21:0] x);
    @(negedge clk);
    rst = r; start = s; ir = i;
    expq.push_back(x);
    nameq.push_back(n);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic fetch(string n, logic [7:0] i, bit il);
    step({n, "_f0"}, 0, 0, i, e(1,0,il,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step({n, "_f1"}, 0, 0, i, e(1,0,il,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step({n, "_f2"}, 0, 0, i, e(1,0,il,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
  endtask

  localparam logic [21:0] ZERO = 22'h0;

  initial begin
    // Reset, idle, ADD R1,R2 with start held high while busy
    add("rst",       1, 0, 8'h16, ZERO);
    add("idle",      0, 0, 8'h16, ZERO);
    add("add_f0",    0, 1, 8'h16, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("add_f1",    0, 1, 8'h16, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("add_f2",    0, 1, 8'h16, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("add_ex",    0, 0, 8'h16, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd2, 4'h1));
    add("add_wb",    0, 0, 8'h16, e(1,0,0,1, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd2, 4'h1));
    // ADD R1,mem: operand fetch inserted
    add("addm_f0",   0, 0, 8'h14, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("addm_f1",   0, 0, 8'h14, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("addm_f2",   0, 0, 8'h14, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("addm_o0",   0, 0, 8'h14, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd1, 2'd0, 4'h0));
    add("addm_o1",   0, 0, 8'h14, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd1, 2'd0, 4'h0));
    add("addm_o2",   0, 0, 8'h14, e(1,0,0,0, 0,0,1,1,0,0, 4'b0001, 2'd1, 2'd0, 4'h0));
    add("addm_ex",   0, 0, 8'h14, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd0, 4'h1));
    add("addm_wb",   0, 0, 8'h14, e(1,0,0,1, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd0, 4'h1));
    // NOT R1 with src==0: no operand fetch
    add("not_f0",    0, 0, 8'h74, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("not_f1",    0, 0, 8'h74, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("not_f2",    0, 0, 8'h74, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("not_ex",    0, 0, 8'h74, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd0, 4'h7));
    add("not_wb",    0, 0, 8'h74, e(1,0,0,1, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd0, 4'h7));
    // MUL R1,R3 with three execute cycles then LO/HI writeback
    add("mul_f0",    0, 0, 8'h47, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("mul_f1",    0, 0, 8'h47, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("mul_f2",    0, 0, 8'h47, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("mul_ex",    0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    add("mul_md1",   0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    add("mul_md2",   0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    add("mul_wlo",   0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd0, 4'h4));
    add("mul_whi",   0, 0, 8'h47, e(1,0,0,1, 0,0,0,0,0,1, 4'b0100, 2'd2, 2'd0, 4'h4));
    // Illegal opcode: sticky flag, back to fetch, cleared by reset
    add("ill_f0",    0, 0, 8'hC5, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("ill_f1",    0, 0, 8'hC5, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("ill_f2",    0, 0, 8'hC5, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("ill_dec",   0, 0, 8'hC5, e(1,0,0,0, 0,0,0,0,0,0, 4'h0, 2'd1, 2'd1, 4'h0));
    add("ill_f0b",   0, 0, 8'hC5, e(1,0,1,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("ill_f1b",   0, 0, 8'hC5, e(1,0,1,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    add("ill_rst",   1, 0, 8'hC5, ZERO);
    add("ill_idle",  0, 0, 8'hC5, ZERO);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].r, tbl[k].s, tbl[k].i, tbl[k].x);

    // HALT: parks with halted high for 20 cycles, start restarts fetch
    step("halt_f0", 0, 1, 8'h30, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("halt_f1", 0, 0, 8'h30, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("halt_f2", 0, 0, 8'h30, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("halt_dec", 0, 0, 8'h30, e(1,0,0,0, 0,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    for (int c = 0; c < 20; c++)
      step("halt_hold", 0, 0, 8'h30, e(0,1,0,0, 0,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("halt_restart", 0, 1, 8'h30, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));

    // Reset while in MD, with start also high: reset wins
    step("mdr_f1",  0, 0, 8'h47, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("mdr_f2",  0, 0, 8'h47, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("mdr_ex",  0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    step("mdr_md",  0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    step("mdr_rst", 1, 1, 8'h47, ZERO);
    step("mdr_idle", 0, 0, 8'h47, ZERO);
    step("mdr_f0",  0, 1, 8'h47, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("mdr_f1b", 0, 0, 8'h47, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("mdr_f2b", 0, 0, 8'h47, e(1,0,0,0, 0,0,0,1,1,0, 4'h0, 2'd0, 2'd0, 4'h0));
    step("mdr_exb", 0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    step("mdr_md1", 0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    step("mdr_md2", 0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd1, 2'd3, 4'h4));
    step("mdr_wlo", 0, 0, 8'h47, e(1,0,0,0, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd0, 4'h4));
    step("mdr_whi", 0, 0, 8'h47, e(1,0,0,1, 0,0,0,0,0,1, 4'b0100, 2'd2, 2'd0, 4'h4));

    // DIV R2,mem on the fetch that follows: operand path then multi-cycle execute
    fetch("divm", 8'h58, 1'b0);
    step("divm_o0",  0, 0, 8'h58, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd2, 2'd0, 4'h0));
    step("divm_o1",  0, 0, 8'h58, e(1,0,0,0, 0,1,0,0,0,0, 4'h0, 2'd2, 2'd0, 4'h0));
    step("divm_o2",  0, 0, 8'h58, e(1,0,0,0, 0,0,1,1,0,0, 4'b0001, 2'd2, 2'd0, 4'h0));
    step("divm_ex",  0, 0, 8'h58, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd2, 2'd0, 4'h5));
    step("divm_md1", 0, 0, 8'h58, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd2, 2'd0, 4'h5));
    step("divm_md2", 0, 0, 8'h58, e(1,0,0,0, 0,0,0,0,0,1, 4'h0, 2'd2, 2'd0, 4'h5));
    step("divm_wlo", 0, 0, 8'h58, e(1,0,0,0, 0,0,0,0,0,1, 4'b0010, 2'd1, 2'd0, 4'h5));
    step("divm_whi", 0, 0, 8'h58, e(1,0,0,1, 0,0,0,0,0,1, 4'b0100, 2'd2, 2'd0, 4'h5));
    step("divm_next", 0, 0, 8'h58, e(1,0,0,0, 1,0,0,0,0,0, 4'h0, 2'd0, 2'd0, 4'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
